// File: rtl/interrupt_control_pkg.sv
// Shared constants and types for the timer-interrupt acceptance block.
//   - int_state_e     : 2-bit FSM encoding (idle / armed / in handler)
//   - INT_VECTOR_ADDR : kernel handler entry address
//   - EPC_REG_ADDR    : register-file index that receives the return PC ($k0)
//   - USER_STATE      : value of PC[31] meaning user mode
//   - RST_ENABLE      : asserted level of the asynchronous reset
//   - ZERO_WORD       : 32-bit zero used for idle output values
//   - epc_value()     : return PC as written to the EPC register
package interrupt_control_pkg;

  typedef enum logic [1:0] {
    IntIdle    = 2'b00,
    IntArmed   = 2'b01,
    IntHandler = 2'b10
  } int_state_e;

  localparam logic [31:0] INT_VECTOR_ADDR = 32'h8000_0004;
  localparam logic [4:0]  EPC_REG_ADDR    = 5'd26;
  localparam logic        USER_STATE      = 1'b0;
  localparam logic        RST_ENABLE      = 1'b0;
  localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;

  // The privilege bit is cleared so the handler always returns to user space.
  function automatic logic [31:0] epc_value(input logic [31:0] pc);
    return {1'b0, pc[30:0]};
  endfunction

endpackage

// File: rtl/interrupt_control.sv
// Timer-interrupt acceptance for the five-stage pipeline.
// Latches the level request from the timer, waits for a safe instruction boundary in ID while
// running in user mode, then emits a one-cycle take pulse that flushes IF/ID, redirects the PC to
// the kernel vector and writes the victim PC into the EPC register. Re-entry is blocked until the
// handler returns; accepted interrupts are counted.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active low
//   intreq_i      in   level interrupt request (timer TCON[2])
//   pc31_i        in   privilege bit of the IF-stage PC (0 = user)
//   id_pc_i       in   PC of the instruction in ID
//   id_valid_i    in   ID holds a real instruction
//   stall_i       in   load-use stall this cycle
//   ex_flush_i    in   taken branch/jump in EX flushing ID this cycle
//   eret_i        in   handler return (jr $k0) advancing from ID
//   int_take_o    out  accept pulse: flush IF/ID, load PC with INT_VECTOR
//   int_vector_o  out  INT_VECTOR during the take pulse, else 0
//   epc_we_o      out  EPC register-file write enable (same as int_take_o)
//   epc_waddr_o   out  EPC_REG during the write, else 0
//   epc_wdata_o   out  return PC with bit 31 cleared during the write, else 0
//   epc_o         out  last saved EPC
//   in_handler_o  out  high from take until handler return
//   int_count_o   out  number of accepted interrupts (wraps silently)
module interrupt_control
  import interrupt_control_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR = INT_VECTOR_ADDR,
  parameter logic [4:0]  EPC_REG    = EPC_REG_ADDR,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             intreq_i,
  input  logic             pc31_i,
  input  logic [31:0]      id_pc_i,
  input  logic             id_valid_i,
  input  logic             stall_i,
  input  logic             ex_flush_i,
  input  logic             eret_i,
  output logic             int_take_o,
  output logic [31:0]      int_vector_o,
  output logic             epc_we_o,
  output logic [4:0]       epc_waddr_o,
  output logic [31:0]      epc_wdata_o,
  output logic [31:0]      epc_o,
  output logic             in_handler_o,
  output logic [CNT_W-1:0] int_count_o
);

  int_state_e       state_q, state_d;
  logic [31:0]      epc_q;
  logic [CNT_W-1:0] count_q;
  logic             safe;
  logic             take;

  // A boundary is safe only for a real, advancing, unflushed user-mode instruction in ID.
  assign safe = id_valid_i & ~stall_i & ~ex_flush_i & (id_pc_i[31] == USER_STATE);

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IntIdle: begin
        if (intreq_i && (pc31_i == USER_STATE)) state_d = IntArmed;
      end
      IntArmed: begin
        // Dropped request or kernel entry (syscall) cancels the pending interrupt.
        if (!intreq_i || (pc31_i != USER_STATE)) begin
          state_d = IntIdle;
        end else if (safe) begin
          take    = 1'b1;
          state_d = IntHandler;
        end
      end
      IntHandler: begin
        if (eret_i) state_d = IntIdle;
      end
      default: state_d = IntIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= IntIdle;
      epc_q   <= ZERO_WORD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        epc_q   <= id_pc_i;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign int_take_o   = take;
  assign int_vector_o = take ? INT_VECTOR : ZERO_WORD;
  assign epc_we_o     = take;
  assign epc_waddr_o  = take ? EPC_REG : 5'd0;
  assign epc_wdata_o  = take ? epc_value(id_pc_i) : ZERO_WORD;
  assign epc_o        = epc_q;
  assign in_handler_o = (state_q == IntHandler);
  assign int_count_o  = count_q;

endmodule

// File: tb/tb_interrupt_control.sv
// Self-checking bench for interrupt_control: a table of per-cycle vectors plus hand-written
// sequences (kernel masking, counter wrap, asynchronous reset mid-handler). Expectations are
// queued when stimulus is driven and popped and compared when outputs are sampled.
module tb_interrupt_control;
  import interrupt_control_pkg::*;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          intreq_i, pc31_i, id_valid_i, stall_i, ex_flush_i, eret_i;
  logic [31:0]   id_pc_i;
  logic          int_take_o, epc_we_o, in_handler_o;
  logic [31:0]   int_vector_o, epc_wdata_o, epc_o;
  logic [4:0]    epc_waddr_o;
  logic [CW-1:0] int_count_o;

  interrupt_control #(
    .INT_VECTOR(32'h8000_0004),
    .EPC_REG   (5'd26),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .intreq_i    (intreq_i),
    .pc31_i      (pc31_i),
    .id_pc_i     (id_pc_i),
    .id_valid_i  (id_valid_i),
    .stall_i     (stall_i),
    .ex_flush_i  (ex_flush_i),
    .eret_i      (eret_i),
    .int_take_o  (int_take_o),
    .int_vector_o(int_vector_o),
    .epc_we_o    (epc_we_o),
    .epc_waddr_o (epc_waddr_o),
    .epc_wdata_o (epc_wdata_o),
    .epc_o       (epc_o),
    .in_handler_o(in_handler_o),
    .int_count_o (int_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          intreq;
    logic          pc31;
    logic [31:0]   id_pc;
    logic          id_valid;
    logic          stall;
    logic          ex_flush;
    logic          eret;
    logic          e_take;
    logic          e_hand;
    logic [CW-1:0] e_cnt;
    logic [31:0]   e_epc;
  } vec_t;

  typedef struct {
    logic          take;
    logic          hand;
    logic [CW-1:0] cnt;
    logic [31:0]   epc;
    logic [31:0]   wdata;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic intreq, input logic pc31, input logic [31:0] pc,
                              input logic valid, input logic stall, input logic flush,
                              input logic eret, input logic take, input logic hand,
                              input int cnt, input logic [31:0] epc);
    vec_t v;
    v.intreq = intreq; v.pc31 = pc31; v.id_pc = pc; v.id_valid = valid;
    v.stall = stall; v.ex_flush = flush; v.eret = eret;
    v.e_take = take; v.e_hand = hand; v.e_cnt = CW'(cnt); v.e_epc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    intreq_i = v.intreq; pc31_i = v.pc31; id_pc_i = v.id_pc; id_valid_i = v.id_valid;
    stall_i = v.stall; ex_flush_i = v.ex_flush; eret_i = v.eret;
    e.take  = v.e_take;
    e.hand  = v.e_hand;
    e.cnt   = v.e_cnt;
    e.epc   = v.e_epc;
    e.wdata = v.e_take ? {1'b0, v.id_pc[30:0]} : 32'h0;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: empty, expected 1 entry");
      return;
    end
    e = sb.pop_front();
    chk("int_take",   {31'b0, int_take_o},   {31'b0, e.take});
    chk("int_vector", int_vector_o,          e.take ? 32'h8000_0004 : 32'h0);
    chk("epc_we",     {31'b0, epc_we_o},     {31'b0, e.take});
    chk("epc_waddr",  {27'b0, epc_waddr_o},  e.take ? 32'd26 : 32'd0);
    chk("epc_wdata",  epc_wdata_o,           e.wdata);
    chk("in_handler", {31'b0, in_handler_o}, {31'b0, e.hand});
    chk("int_count",  32'(int_count_o),      32'(e.cnt));
    chk("epc",        epc_o,                 e.epc);
  endtask

  // Drive just after the rising edge, sample on the falling edge.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    logic [CW-1:0] c;
    logic [31:0]   last_epc;
    logic [31:0]   pc;

    rst = 1'b0;
    drive(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    #12;
    check_out();
    @(posedge clk);
    #1 rst = 1'b1;

    //           req pc31 id_pc        vld stl fl er  take hnd cnt epc
    tbl.push_back(mk(0, 0, 32'h0000_0040, 1, 0, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h0000_0040, 1, 0, 0, 0, 0, 0, 0, 32'h0));   // idle, request sampled
    tbl.push_back(mk(1, 0, 32'h0000_0040, 1, 0, 0, 0, 1, 0, 0, 32'h0));   // basic take
    tbl.push_back(mk(1, 0, 32'h0000_0044, 1, 0, 0, 0, 0, 1, 1, 32'h40));  // in handler, req ignored
    tbl.push_back(mk(0, 0, 32'h0000_0048, 1, 0, 0, 1, 0, 1, 1, 32'h40));  // eret
    tbl.push_back(mk(1, 0, 32'h0000_00f0, 1, 1, 0, 0, 0, 0, 1, 32'h40));  // idle -> armed
    tbl.push_back(mk(1, 0, 32'h0000_00f0, 1, 1, 0, 0, 0, 0, 1, 32'h40));  // stall 1
    tbl.push_back(mk(1, 0, 32'h0000_00f0, 1, 1, 0, 0, 0, 0, 1, 32'h40));  // stall 2
    tbl.push_back(mk(1, 0, 32'h0000_00f0, 1, 1, 0, 0, 0, 0, 1, 32'h40));  // stall 3
    tbl.push_back(mk(1, 0, 32'h0000_00f4, 1, 0, 1, 0, 0, 0, 1, 32'h40));  // ex flush
    tbl.push_back(mk(1, 0, 32'h0000_0100, 1, 0, 0, 0, 1, 0, 1, 32'h40));  // first clean cycle
    tbl.push_back(mk(1, 0, 32'h0000_0104, 1, 0, 0, 1, 0, 1, 2, 32'h100)); // eret, req held
    tbl.push_back(mk(1, 0, 32'h0000_0200, 1, 0, 0, 0, 0, 0, 2, 32'h100)); // idle
    tbl.push_back(mk(1, 0, 32'h0000_0200, 1, 0, 0, 0, 1, 0, 2, 32'h100)); // re-entry 2 cycles on
    tbl.push_back(mk(0, 0, 32'h0000_0204, 1, 0, 0, 0, 0, 1, 3, 32'h200)); // req cleared
    tbl.push_back(mk(0, 0, 32'h0000_0208, 1, 0, 0, 1, 0, 1, 3, 32'h200)); // eret
    tbl.push_back(mk(0, 0, 32'h0000_0210, 1, 0, 0, 0, 0, 0, 3, 32'h200)); // no further take
    tbl.push_back(mk(0, 0, 32'h0000_0214, 1, 0, 0, 0, 0, 0, 3, 32'h200));
    tbl.push_back(mk(1, 0, 32'h0000_0300, 1, 0, 0, 0, 0, 0, 3, 32'h200)); // idle -> armed
    tbl.push_back(mk(1, 0, 32'h0000_0300, 0, 0, 0, 0, 0, 0, 3, 32'h200)); // bubble holds
    tbl.push_back(mk(1, 0, 32'h8000_0010, 1, 0, 0, 0, 0, 0, 3, 32'h200)); // kernel PC in ID
    tbl.push_back(mk(0, 0, 32'h0000_0300, 1, 0, 0, 0, 0, 0, 3, 32'h200)); // req drop -> idle
    tbl.push_back(mk(1, 0, 32'h0000_0300, 1, 0, 0, 0, 0, 0, 3, 32'h200)); // idle again, no take
    tbl.push_back(mk(1, 1, 32'h0000_0300, 1, 0, 0, 0, 0, 0, 3, 32'h200)); // syscall entry -> idle
    tbl.push_back(mk(1, 0, 32'h0000_0300, 1, 0, 0, 0, 0, 0, 3, 32'h200)); // idle again, no take
    tbl.push_back(mk(1, 0, 32'h0000_0300, 1, 0, 0, 0, 1, 0, 3, 32'h200)); // take
    tbl.push_back(mk(0, 0, 32'h0000_0304, 1, 0, 0, 1, 0, 1, 4, 32'h300)); // eret
    tbl.push_back(mk(0, 0, 32'h0000_0308, 1, 0, 0, 0, 0, 0, 4, 32'h300));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Kernel masking: request held while running in kernel mode never arms.
    for (int i = 0; i < 10; i++) step(mk(1, 1, 32'h8000_0010, 1, 0, 0, 0, 0, 0, 4, 32'h300));
    step(mk(1, 0, 32'h0000_0040, 1, 0, 0, 0, 0, 0, 4, 32'h300));
    step(mk(1, 0, 32'h0000_0040, 1, 0, 0, 0, 1, 0, 4, 32'h300));
    step(mk(0, 0, 32'h0000_0044, 1, 0, 0, 1, 0, 1, 5, 32'h40));

    // Counter wrap: 16 more takes bring the 4-bit count back round through 0.
    c        = CW'(5);
    last_epc = 32'h40;
    for (int i = 0; i < 16; i++) begin
      pc = 32'h0000_1000 + 32'(i * 4);
      step(mk(1, 0, pc, 1, 0, 0, 0, 0, 0, int'(c), last_epc));
      step(mk(1, 0, pc, 1, 0, 0, 0, 1, 0, int'(c), last_epc));
      c        = c + CW'(1);
      last_epc = pc;
      step(mk(0, 0, pc + 32'd4, 1, 0, 0, 1, 0, 1, int'(c), last_epc));
    end

    // Asynchronous reset mid-handler clears everything within the cycle.
    step(mk(1, 0, 32'h0000_0500, 1, 0, 0, 0, 0, 0, int'(c), last_epc));
    step(mk(1, 0, 32'h0000_0500, 1, 0, 0, 0, 1, 0, int'(c), last_epc));
    c = c + CW'(1);
    step(mk(1, 0, 32'h0000_0504, 1, 0, 0, 0, 0, 1, int'(c), 32'h500));
    #2 rst = 1'b0;
    #1;
    drive(mk(1, 0, 32'h0000_0504, 1, 0, 0, 0, 0, 0, 0, 32'h0));
    check_out();
    drive(mk(1, 0, 32'h0000_0504, 1, 0, 0, 0, 0, 0, 0, 32'h0));
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1 rst = 1'b1;
    drive(mk(1, 0, 32'h0000_0600, 1, 0, 0, 0, 0, 0, 0, 32'h0));
    @(negedge clk);
    check_out();
    step(mk(1, 0, 32'h0000_0600, 1, 0, 0, 0, 1, 0, 0, 32'h0));
    step(mk(0, 0, 32'h0000_0604, 1, 0, 0, 1, 0, 1, 1, 32'h600));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
